// File: rtl/sprite_plotter.sv
// Sprite plotter: scans a full-screen, bubble or item image out of an external ROM and emits one VGA pixel write per cycle.
// Optional build macro PLOTTER_TRANSPARENCY_EN suppresses bubble/item pixels whose colour equals TRANSP_COLOUR.
module sprite_plotter #(
    parameter int unsigned          COLOUR_W      = 3,
    parameter int unsigned          SCREEN_W      = 160,
    parameter int unsigned          SCREEN_H      = 120,
    parameter int unsigned          BUBBLE_W      = 32,
    parameter int unsigned          BUBBLE_H      = 32,
    parameter int unsigned          BUBBLE_X      = 96,
    parameter int unsigned          BUBBLE_Y      = 8,
    parameter int unsigned          ITEM_W        = 16,
    parameter int unsigned          ITEM_H        = 16,
    parameter logic [COLOUR_W-1:0]  TRANSP_COLOUR = 3'b101
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 draw_scrn_start,
    input  logic                 draw_scrn_game_bg,
    input  logic                 draw_gameover,
    input  logic                 draw_hungerbubble,
    input  logic                 draw_boredbubble,
    input  logic                 draw_sickbubble,
    input  logic                 draw_dirtybubble,
    input  logic                 draw_dyingbubble,
    input  logic                 draw_zzzs,
    input  logic                 draw_ball,
    input  logic                 draw_food,
    input  logic                 draw_broom,
    input  logic                 draw_pills,
    input  logic                 draw_firstAid,
    input  logic [7:0]           obj_x,
    input  logic [6:0]           obj_y,
    output logic [3:0]           rom_sel,
    output logic [14:0]          rom_addr,
    input  logic [COLOUR_W-1:0]  rom_data,
    output logic [7:0]           vga_x,
    output logic [6:0]           vga_y,
    output logic [COLOUR_W-1:0]  vga_colour,
    output logic                 vga_plot,
    output logic                 plot_done,
    output logic                 busy
);

    localparam int unsigned N_SRC      = 14;
    localparam int unsigned SEL_W      = 4;
    localparam int unsigned X_W        = 8;
    localparam int unsigned Y_W        = 7;
    localparam int unsigned COORD_W    = 9;
    localparam int unsigned ADDR_W     = 15;
    localparam int unsigned LAST_SCRN  = 2;
    localparam int unsigned LAST_BUBL  = 8;

`ifdef PLOTTER_TRANSPARENCY_EN
    localparam bit TRANSP_EN = 1'b1;
`else
    localparam bit TRANSP_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SCAN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [N_SRC-1:0]    w_req;
    logic [SEL_W-1:0]    w_req_id;
    logic                w_busy;
    logic                w_done;

    logic [SEL_W-1:0]    r_sel;
    logic [X_W-1:0]      r_ox;
    logic [Y_W-1:0]      r_oy;
    logic [X_W-1:0]      r_w;
    logic [Y_W-1:0]      r_h;
    logic [X_W-1:0]      r_cx;
    logic [Y_W-1:0]      r_cy;

    logic                w_row_end;
    logic                w_last;
    logic [COORD_W-1:0]  w_sx;
    logic [COORD_W-1:0]  w_sy;
    logic                w_in_bounds;
    logic                w_key;

    logic [X_W-1:0]      r_vga_x;
    logic [Y_W-1:0]      r_vga_y;
    logic                r_plot_en;
    logic                r_pix_vld;

    assign w_req = {draw_firstAid, draw_pills, draw_broom, draw_food, draw_ball,
                    draw_zzzs, draw_dyingbubble, draw_dirtybubble, draw_sickbubble,
                    draw_boredbubble, draw_hungerbubble,
                    draw_gameover, draw_scrn_game_bg, draw_scrn_start};

    // Lowest asserted source id wins.
    always_comb begin
        w_req_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_req_id = SEL_W'(i);
            end
        end
    end

    assign w_row_end = (r_cx == r_w - X_W'(1));
    assign w_last    = w_row_end && (r_cy == r_h - Y_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (|w_req) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD:  w_next = S_SCAN;
            S_SCAN: begin
                if (w_last) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    // Source latch, image geometry and row-major scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sel <= '0;
            r_ox  <= '0;
            r_oy  <= '0;
            r_w   <= '0;
            r_h   <= '0;
            r_cx  <= '0;
            r_cy  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|w_req) begin
                        r_sel <= w_req_id;
                    end
                end
                S_LOAD: begin
                    r_cx <= '0;
                    r_cy <= '0;
                    if (r_sel <= SEL_W'(LAST_SCRN)) begin
                        r_ox <= '0;
                        r_oy <= '0;
                        r_w  <= X_W'(SCREEN_W);
                        r_h  <= Y_W'(SCREEN_H);
                    end else if (r_sel <= SEL_W'(LAST_BUBL)) begin
                        r_ox <= X_W'(BUBBLE_X);
                        r_oy <= Y_W'(BUBBLE_Y);
                        r_w  <= X_W'(BUBBLE_W);
                        r_h  <= Y_W'(BUBBLE_H);
                    end else begin
                        r_ox <= obj_x;
                        r_oy <= obj_y;
                        r_w  <= X_W'(ITEM_W);
                        r_h  <= Y_W'(ITEM_H);
                    end
                end
                S_SCAN: begin
                    if (w_row_end) begin
                        r_cx <= '0;
                        r_cy <= w_last ? '0 : r_cy + Y_W'(1);
                    end else begin
                        r_cx <= r_cx + X_W'(1);
                    end
                end
                default: begin
                    r_cx <= r_cx;
                end
            endcase
        end
    end

    assign w_sx        = COORD_W'(r_ox) + COORD_W'(r_cx);
    assign w_sy        = COORD_W'(r_oy) + COORD_W'(r_cy);
    assign w_in_bounds = (w_sx < COORD_W'(SCREEN_W)) && (w_sy < COORD_W'(SCREEN_H));

    // Stage 1: coordinates line up with the ROM word that arrives one cycle after its address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vga_x   <= '0;
            r_vga_y   <= '0;
            r_plot_en <= 1'b0;
            r_pix_vld <= 1'b0;
        end else begin
            r_vga_x   <= w_sx[X_W-1:0];
            r_vga_y   <= w_sy[Y_W-1:0];
            r_plot_en <= (r_state == S_SCAN) && w_in_bounds;
            r_pix_vld <= (r_state == S_SCAN);
        end
    end

    // Full-screen sources (ids 0-2) are never keyed.
    assign w_key = TRANSP_EN && (r_sel > SEL_W'(LAST_SCRN)) && (rom_data == TRANSP_COLOUR);

    assign rom_sel    = r_sel;
    assign rom_addr   = ADDR_W'(r_cy) * ADDR_W'(r_w) + ADDR_W'(r_cx);
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_pix_vld ? rom_data : '0;
    assign vga_plot   = r_plot_en && !w_key;
    assign plot_done  = w_done;
    assign busy       = w_busy;

endmodule

// File: tb/tb_sprite_plotter.sv
// Self-checking bench for sprite_plotter: directed cases plus random item/bubble draws against a pixel-index model.
module tb_sprite_plotter;

`ifdef PLOTTER_TRANSPARENCY_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] req;
    logic [7:0]  obj_x;
    logic [6:0]  obj_y;
    logic [3:0]  rom_sel;
    logic [14:0] rom_addr;
    logic [2:0]  rom_data = '0;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        plot_done;
    logic        busy;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;

    int          rom_mode = 0;
    int unsigned rom_seed = 0;

    bit          job_valid = 1'b0;
    int          job_t0, job_id, job_ox, job_oy, job_w, job_h, job_mode;
    int unsigned job_seed;
    logic [3:0]  exp_sel = '0;

    int          wr_cnt, n_key, done_k, first_k, first_x, first_y;
    int          last_x, last_y, last_c, min_x, max_x, min_y, max_y;

    sprite_plotter dut (
        .clk               (clk),
        .reset             (reset),
        .draw_scrn_start   (req[0]),
        .draw_scrn_game_bg (req[1]),
        .draw_gameover     (req[2]),
        .draw_hungerbubble (req[3]),
        .draw_boredbubble  (req[4]),
        .draw_sickbubble   (req[5]),
        .draw_dirtybubble  (req[6]),
        .draw_dyingbubble  (req[7]),
        .draw_zzzs         (req[8]),
        .draw_ball         (req[9]),
        .draw_food         (req[10]),
        .draw_broom        (req[11]),
        .draw_pills        (req[12]),
        .draw_firstAid     (req[13]),
        .obj_x             (obj_x),
        .obj_y             (obj_y),
        .rom_sel           (rom_sel),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .vga_x             (vga_x),
        .vga_y             (vga_y),
        .vga_colour        (vga_colour),
        .vga_plot          (vga_plot),
        .plot_done         (plot_done),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2:0] rom_fn(input int mode, input int unsigned seed, input int unsigned a);
        logic [31:0] t;
        case (mode)
            0:       t = a;
            1:       t = (a * 32'd37 + seed) >> 3;
            default: t = a[0] ? 32'd2 : 32'd5;
        endcase
        return t[2:0];
    endfunction

    // External image ROM: one cycle read latency.
    always @(posedge clk) rom_data <= rom_fn(rom_mode, rom_seed, 32'(rom_addr));

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the image model: pixel i of a job appears in cycle 3+i.
    always @(negedge clk) begin
        int k, n, i, px, py, c;
        bit e_busy, e_done, e_plot;
        if (reset) begin
            exp_sel = '0;
        end else begin
            e_busy = 1'b0;
            e_done = 1'b0;
            e_plot = 1'b0;
            px = 0; py = 0; c = 0;
            if (job_valid) begin
                k = cyc - job_t0;
                n = job_w * job_h;
                if (k == 0) begin
                    wr_cnt = 0; n_key = 0; done_k = -1; first_k = -1;
                    min_x = 999; max_x = -1; min_y = 999; max_y = -1;
                end
                if (k >= 1) exp_sel = 4'(job_id);
                e_busy = (k >= 1) && (k <= n + 3);
                e_done = (k == n + 3);
                if (k >= 2 && k <= n + 1) chk("rom_addr", int'(rom_addr), k - 2);
                if (k >= 3 && k <= n + 2) begin
                    i  = k - 3;
                    px = job_ox + i % job_w;
                    py = job_oy + i / job_w;
                    c  = int'(rom_fn(job_mode, job_seed, i));
                    e_plot = (px < 160) && (py < 120) && !(TEN && job_id >= 3 && c == 5);
                end
                if (vga_plot) begin
                    if (first_k < 0) begin
                        first_k = k; first_x = int'(vga_x); first_y = int'(vga_y);
                    end
                    wr_cnt++;
                    if (vga_colour == 3'd5) n_key++;
                    last_x = int'(vga_x); last_y = int'(vga_y); last_c = int'(vga_colour);
                    if (int'(vga_x) < min_x) min_x = int'(vga_x);
                    if (int'(vga_x) > max_x) max_x = int'(vga_x);
                    if (int'(vga_y) < min_y) min_y = int'(vga_y);
                    if (int'(vga_y) > max_y) max_y = int'(vga_y);
                end
                if (plot_done) done_k = k;
            end
            chk("busy", int'(busy), int'(e_busy));
            chk("plot_done", int'(plot_done), int'(e_done));
            chk("vga_plot", int'(vga_plot), int'(e_plot));
            chk("rom_sel", int'(rom_sel), int'(exp_sel));
            if (e_plot) begin
                chk("vga_x", int'(vga_x), px);
                chk("vga_y", int'(vga_y), py);
                chk("vga_colour", int'(vga_colour), c);
            end
        end
    end

    // Runs one draw from the IDLE cycle in which the request is raised; returns in the next IDLE cycle.
    task automatic run_job(input logic [13:0] r, input int id, input int ox, input int oy,
                           input int mode, input bit junk, input bit drop,
                           input logic [13:0] tail, input int abort_k);
        int n;
        if (id <= 2) begin
            job_ox = 0;  job_oy = 0; job_w = 160; job_h = 120;
        end else if (id <= 8) begin
            job_ox = 96; job_oy = 8; job_w = 32;  job_h = 32;
        end else begin
            job_ox = ox; job_oy = oy; job_w = 16; job_h = 16;
        end
        obj_x     = 8'(ox);
        obj_y     = 7'(oy);
        rom_mode  = mode;
        rom_seed  = $urandom;
        job_mode  = mode;
        job_seed  = rom_seed;
        job_id    = id;
        job_t0    = cyc;
        job_valid = 1'b1;
        req       = r;
        n = job_w * job_h;
        for (int k = 1; k <= n + 4; k++) begin
            @(posedge clk);
            #1;
            if (k == abort_k) begin
                #1 reset = 1'b1;
                #1;
                chk("rst_busy", int'(busy), 0);
                chk("rst_plot", int'(vga_plot), 0);
                chk("rst_done", int'(plot_done), 0);
                chk("rst_sel", int'(rom_sel), 0);
                chk("rst_addr", int'(rom_addr), 0);
                chk("rst_xy", int'(vga_x) + int'(vga_y), 0);
                chk("rst_colour", int'(vga_colour), 0);
                job_valid = 1'b0;
                req = '0;
                @(posedge clk);
                #1 reset = 1'b0;
                return;
            end
            if (k == 2 && drop) req = '0;
            if (junk && k >= 2 && k < n) begin
                req   = 14'($urandom);
                obj_x = 8'($urandom);
                obj_y = 7'($urandom);
            end
            if (k == n) req = tail;
        end
    endtask

    initial begin
        logic [13:0] r;
        int id, ox, oy;
        reset = 1'b1;
        req   = '0;
        obj_x = '0;
        obj_y = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_plot", int'(vga_plot), 0);
        chk("reset_sel", int'(rom_sel), 0);
        chk("reset_addr", int'(rom_addr), 0);

        run_job(14'h0002, 1, 0, 0, 0, 1'b0, 1'b0, '0, 0);
        chk("scr_writes", wr_cnt, 19200);
        chk("scr_first_k", first_k, 3);
        chk("scr_first_xy", first_x + first_y, 0);
        chk("scr_last_x", last_x, 159);
        chk("scr_last_y", last_y, 119);
        chk("scr_last_c", last_c, 7);
        chk("scr_done_k", done_k, 19203);

        run_job(14'h0200, 9, 10, 20, 0, 1'b0, 1'b0, '0, 0);
        chk("ball_writes", wr_cnt, 256);
        chk("ball_min_x", min_x, 10);
        chk("ball_max_x", max_x, 25);
        chk("ball_min_y", min_y, 20);
        chk("ball_max_y", max_y, 35);
        chk("ball_sel", int'(rom_sel), 9);
        chk("ball_done_k", done_k, 259);

        run_job(14'h0400, 10, 150, 115, 0, 1'b0, 1'b1, '0, 0);
        chk("food_writes", wr_cnt, 50);
        chk("food_done_k", done_k, 259);

        run_job(14'h0208, 3, 10, 20, 0, 1'b0, 1'b0, 14'h0200, 0);
        chk("bub_sel", int'(rom_sel), 3);
        chk("bub_done_k", done_k, 1027);
        chk("bub_writes", wr_cnt, 1024);
        run_job(14'h0200, 9, 10, 20, 0, 1'b0, 1'b0, '0, 0);
        chk("b2b_sel", int'(rom_sel), 9);
        chk("b2b_done_k", done_k, 259);

        run_job(14'h0001, 0, 0, 0, 0, 1'b0, 1'b0, '0, 100);
        run_job(14'h0100, 8, 0, 0, 0, 1'b0, 1'b0, '0, 0);
        chk("zzz_done_k", done_k, 1027);

        run_job(14'h0200, 9, 40, 40, 2, 1'b0, 1'b0, '0, 0);
        chk("key_writes", wr_cnt, TEN ? 128 : 256);
        chk("key_colour5", n_key, TEN ? 0 : 128);

        for (int t = 0; t < 24; t++) begin
            id = ($urandom_range(0, 9) < 2) ? $urandom_range(3, 8) : $urandom_range(9, 13);
            r  = 14'(1 << id);
            r  = r | (14'($urandom) & (14'h3FFE << id));
            ox = (t % 3 == 0) ? $urandom_range(140, 255) : $urandom_range(0, 150);
            oy = (t % 3 == 1) ? $urandom_range(100, 127) : $urandom_range(0, 110);
            run_job(r, id, ox, oy, 1, 1'($urandom), 1'($urandom), '0, 0);
        end

        repeat (4) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/sprite_plotter.md
# sprite_plotter

Pixel-plotting datapath that sits between the game control FSM and the 160x120 VGA adapter. It accepts the one-hot `draw_*` requests and scans the selected image (full screen, status bubble or item sprite) through an external image ROM, emitting one VGA pixel write per cycle. When the image is complete it pulses `plot_done`, which lets the control FSM advance.

## Interface
- `COLOUR_W`, 3: VGA colour width.
- `SCREEN_W`, 160 / `SCREEN_H`, 120: full-screen image size.
- `BUBBLE_W`, 32 / `BUBBLE_H`, 32 / `BUBBLE_X`, 96 / `BUBBLE_Y`, 8: bubble/zzzs size and fixed origin.
- `ITEM_W`, 16 / `ITEM_H`, 16: item sprite size.
- `TRANSP_COLOUR`, 3'b101: transparent key; used only with `PLOTTER_TRANSPARENCY_EN`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high reset.
- `draw_scrn_start`, `draw_scrn_game_bg`, `draw_gameover` in 1 each: full-screen requests; source ids 0, 1, 2.
- `draw_hungerbubble`, `draw_boredbubble`, `draw_sickbubble`, `draw_dirtybubble`, `draw_dyingbubble`, `draw_zzzs` in 1 each: bubble requests; ids 3–8.
- `draw_ball`, `draw_food`, `draw_broom`, `draw_pills`, `draw_firstAid` in 1 each: item requests; ids 9–13.
- `obj_x` in 8: item origin x, latched in LOAD.
- `obj_y` in 7: item origin y, latched in LOAD.
- `rom_sel` out 4: latched source id.
- `rom_addr` out 15: image-relative pixel address.
- `rom_data` in `COLOUR_W`: pixel colour; valid one cycle after `rom_addr`.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out `COLOUR_W`, `vga_plot` out 1: VGA write port.
- `plot_done` out 1: one-cycle completion pulse.
- `busy` out 1: high in every state except IDLE.

## Operation
- States:
  - IDLE: wait for a request.
  - LOAD: latch origin, width and height.
  - SCAN: one ROM address per cycle, row-major.
  - FLUSH: emit the final pixel.
  - DONE: `plot_done` = 1.
- IDLE → LOAD when any `draw_*` is high. If several are high, the lowest id wins; the id is latched into `rom_sel` and held until the next LOAD.
- LOAD origin and size:
  - Full screen: origin (0,0), size `SCREEN_W` x `SCREEN_H`.
  - Bubble: origin (`BUBBLE_X`,`BUBBLE_Y`), size `BUBBLE_W` x `BUBBLE_H`.
  - Item: origin (`obj_x`,`obj_y`), size `ITEM_W` x `ITEM_H`.
- SCAN: column counter `cx` increments every cycle; it wraps to 0 at width−1 and increments row counter `cy`. `rom_addr` = `cy`*width + `cx`, combinational from the counters; the maximum is 19199, which fits in 15 bits. SCAN → FLUSH after `cx`=width−1 and `cy`=height−1.
- FLUSH → DONE, then DONE → IDLE unconditionally.
- `draw_*` is ignored outside IDLE. Dropping a request mid-scan does not abort it.
- Screen coordinates: origin + offset, computed at 9 bits. If x ≥ `SCREEN_W` or y ≥ `SCREEN_H`, the pixel is clipped: `vga_plot` = 0 and the scan continues.
- Reset, at any time including mid-scan: state = IDLE, counters = 0.

## Timing
- All outputs reset to 0. `rom_sel` resets to 0.
- Stage-1 registers: `vga_x`, `vga_y` and plot-enable are delayed copies of the SCAN cycle k coordinates; valid in cycle k+1.
- `vga_colour` = `rom_data` in cycle k+1, aligned with `vga_x`/`vga_y`.
- Request seen at cycle 0 (IDLE):
  - LOAD at cycle 1; first `rom_addr` at cycle 2; first `vga_plot` at cycle 3.
  - N = width*height pixels: SCAN occupies cycles 2..N+1, FLUSH is cycle N+2, `plot_done` is high in cycle N+3 only.
- Full screen: `plot_done` at cycle 19203. Bubble: cycle 1027. Item: cycle 259.
- A new request can be accepted in the cycle after DONE. This supports back-to-back bubble → item draws.
- `vga_plot` is never high in IDLE, LOAD or DONE.

## Configuration
- `PLOTTER_TRANSPARENCY_EN` defined: for bubble and item sources only (ids 3–13), a pixel whose `rom_data` == `TRANSP_COLOUR` has `vga_plot` forced to 0. Full-screen sources always plot. Cycle timing is unchanged.
- Undefined: every in-bounds pixel plots, whatever its colour.

## Test plan
- `draw_scrn_game_bg` held from cycle 0 with ROM data = addr[2:0]:
  - Expect 19200 writes: first at cycle 3 at (0,0), last at (159,119) with colour 19199%8 = 7.
  - Expect `plot_done` only at cycle 19203.
- `draw_ball` with `obj_x`=10, `obj_y`=20:
  - Expect 256 writes covering x 10–25, y 20–35, with `rom_sel`=9.
  - Expect `plot_done` at cycle 259.
- `draw_food` with `obj_x`=150, `obj_y`=115: expect only 10x5 = 50 writes; `plot_done` still at cycle 259.
- `draw_hungerbubble` and `draw_ball` high together: expect `rom_sel`=3 and a bubble scan. With ball held, a second scan with `rom_sel`=9 must start the cycle after DONE.
- `reset` pulsed at cycle 100 of a full-screen draw:
  - Expect all outputs 0 immediately (asynchronously) and state IDLE.
  - After release, a new `draw_zzzs` completes in 1027 cycles.
- With `PLOTTER_TRANSPARENCY_EN` defined and item ROM returning 3'b101 on even addresses: expect 128 writes, all colour ≠ 3'b101. Without the macro: expect 256 writes.
